// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
package bcd2bin_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned MAX_DIGIT   = 9;
  localparam int unsigned CORR_THRESH = 8;
  localparam int unsigned CORR_OFFSET = 3;

endpackage

// File: rtl/bcd2bin_seq_sub3.sv
// Reverse double-dabble digit correction: subtract 3 when the digit is 8 or more.
module bcd2bin_seq_sub3
  import bcd2bin_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] corrected
);

  always_comb begin
    corrected = digit;
    if (digit >= DIGIT_W'(CORR_THRESH))
      corrected = digit - DIGIT_W'(CORR_OFFSET);
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter, one shift-and-correct step per clock,
// valid/ready handshake on input and output.
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int unsigned NDIGITS = 3,
  parameter int unsigned BIN_W   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NDIGITS-1:0]   in_bcd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIN_W-1:0]       out_bin,
  output logic                   out_err
);

  localparam int unsigned BCD_W = DIGIT_W * NDIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  state_t             state, stateNext;
  logic [BCD_W-1:0]   bcdReg, bcdShift, bcdCorr;
  logic [BIN_W-1:0]   binReg, binShift;
  logic [CNT_W-1:0]   cnt;
  logic               badDigit;
  logic               lastStep;

  assign {bcdShift, binShift} = {bcdReg, binReg} >> 1;
  assign lastStep = (cnt == CNT_W'(BIN_W - 1));

  // Each digit is corrected from its own post-shift value, all in parallel.
  for (genvar g = 0; g < NDIGITS; g++) begin : genSub3
    bcd2bin_seq_sub3 uSub3 (
      .digit     (bcdShift[g*DIGIT_W +: DIGIT_W]),
      .corrected (bcdCorr[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_comb begin
    badDigit = 1'b0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (in_bcd[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(MAX_DIGIT))
        badDigit = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = badDigit ? DONE : CONV;
      end
      CONV: begin
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcdReg  <= '0;
      binReg  <= '0;
      cnt     <= '0;
      out_bin <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (badDigit) begin
              out_bin <= '0;
              out_err <= 1'b1;
            end else begin
              bcdReg  <= in_bcd;
              binReg  <= '0;
              cnt     <= '0;
              out_err <= 1'b0;
            end
          end
        end
        CONV: begin
          bcdReg <= bcdCorr;
          binReg <= binShift;
          cnt    <= cnt + CNT_W'(1);
          if (lastStep) out_bin <= binShift;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed table, random vectors,
// backpressure, async reset abort and a full 000..999 handshake sweep.
module tb_bcd2bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_bin;
  logic        out_err;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic [11:0] bcd;
    int          expBin;
    int          expErr;
    int          expLat;
  } vec_t;

  vec_t vecs[7];
  int   q[$];

  always #5 clk = ~clk;

  bcd2bin_seq #(.NDIGITS(3), .BIN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bin   (out_bin),
    .out_err   (out_err)
  );

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Decimal value of a packed BCD word; any digit above 9 is an error with result 0.
  function automatic void refConv(input logic [11:0] bcd, output int bin, output int err);
    int dig;
    bin = 0;
    err = 0;
    for (int d = 2; d >= 0; d--) begin
      dig = int'((bcd >> (4 * d)) & 12'hF);
      if (dig > 9) err = 1;
      bin = bin * 10 + dig;
    end
    if (err != 0) bin = 0;
  endfunction

  function automatic logic [11:0] toBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Leaves the caller at 1 time unit after the accepting edge.
  task automatic send(input logic [11:0] bcd);
    int n;
    in_valid = 1'b1;
    in_bcd   = bcd;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic waitOut(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic doConv(input string name, input logic [11:0] bcd,
                        input int expBin, input int expErr, input int expLat);
    int lat;
    send(bcd);
    waitOut(lat);
    check({name, "_lat"}, lat, expLat);
    check({name, "_bin"}, int'(out_bin), expBin);
    check({name, "_err"}, int'(out_err), expErr);
    @(posedge clk); #1;
    check({name, "_drop"}, int'(out_valid), 0);
  endtask

  initial begin
    int bin, err, lat, sent, got, cyc;
    bit accIn, accOut;
    logic [11:0] r;

    // Error results appear at the accepting edge itself, so 0 further edges.
    vecs[0] = '{12'h255, 255, 0, 10};
    vecs[1] = '{12'h999, 999, 0, 10};
    vecs[2] = '{12'h000, 0,   0, 10};
    vecs[3] = '{12'h1A5, 0,   1, 0};
    vecs[4] = '{12'h042, 42,  0, 10};
    vecs[5] = '{12'hF00, 0,   1, 0};
    vecs[6] = '{12'h809, 809, 0, 10};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b1;
    #2;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bin",   int'(out_bin),   0);
    check("rst_out_err",   int'(out_err),   0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      doConv($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].expBin, vecs[i].expErr, vecs[i].expLat);

    for (int i = 0; i < 20; i++) begin
      r = 12'($urandom);
      refConv(r, bin, err);
      doConv($sformatf("rnd_%03h", r), r, bin, err, (err != 0) ? 0 : 10);
    end

    out_ready = 1'b0;
    send(12'h128);
    waitOut(lat);
    check("bp_lat", lat, 10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_valid", int'(out_valid), 1);
      check("bp_bin",   int'(out_bin),   128);
      check("bp_err",   int'(out_err),   0);
      check("bp_inrdy", int'(in_ready),  0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready),  1);

    send(12'h777);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready",  int'(in_ready),  1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_bin",   int'(out_bin),   0);
    check("abort_out_err",   int'(out_err),   0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    doConv("after_abort", 12'h300, 300, 0, 10);

    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1000 && cyc < 40000) begin
      if (!in_valid && sent < 1000 && $urandom_range(0, 2) != 0) begin
        in_valid = 1'b1;
        in_bcd   = toBcd(sent);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      accIn  = in_valid && in_ready;
      accOut = out_valid && out_ready;
      if (accOut) begin
        if (q.size() == 0) begin
          check("sweep_unexpected", q.size(), 1);
        end else begin
          bin = q.pop_front();
          check($sformatf("sweep_bin_%0d", bin), int'(out_bin), bin);
          check($sformatf("sweep_err_%0d", bin), int'(out_err), 0);
        end
        got++;
      end
      if (accIn) begin
        q.push_back(sent);
        sent++;
      end
      @(posedge clk); #1;
      if (accIn) in_valid = 1'b0;
      cyc++;
    end
    check("sweep_received", got, 1000);
    check("sweep_sent", sent, 1000);
    check("sweep_leftover", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
